// File: rtl/l2_arb_pkg.sv
// Shared types and sizing helpers for the L2 port arbiter.
package l2_arb_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_t;

  function automatic int line_w(int block_size, int data_width);
    return block_size * data_width;
  endfunction

  function automatic int grant_w(int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first pending index strictly after last, wrapping.
module rr_pick
  import l2_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int GRANT_W = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pend,
  input  logic [GRANT_W-1:0] last,
  output logic               any,
  output logic [GRANT_W-1:0] grant
);

  logic [GRANT_W-1:0] idx;

  assign any = |pend;

  // Scan farthest-first so the nearest pending index after last wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GRANT_W'((int'(last) + k) % NUM_REQ);
      if (pend[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Shares one L2 port between NUM_REQ L1 caches: latches pulsed requests,
// grants round-robin, runs one L2 transaction at a time with a watchdog.
module l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BLOCK_SIZE     = 16,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int LINE_W  = line_w(BLOCK_SIZE, DATA_WIDTH),
  localparam int GRANT_W = grant_w(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_read,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0][LINE_W-1:0]    req_wdata,
  output logic [NUM_REQ-1:0][LINE_W-1:0]    req_rdata,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                req_hit,
  output logic [NUM_REQ-1:0]                req_err,
  output logic [ADDR_WIDTH-1:0]             l2_addr,
  output logic [LINE_W-1:0]                 l2_wdata,
  output logic                              l2_read,
  output logic                              l2_write,
  input  logic [LINE_W-1:0]                 l2_rdata,
  input  logic                              l2_ready,
  input  logic                              l2_hit
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t              state, nxt;
  logic [NUM_REQ-1:0]  pend;
  op_t                 op    [NUM_REQ];
  logic [ADDR_WIDTH-1:0] addr [NUM_REQ];
  logic [LINE_W-1:0]   wdata [NUM_REQ];
  logic                pick_any;
  logic [GRANT_W-1:0]  pick, gnt, last;
  logic [WD_W-1:0]     wd;
  logic                hit_q, tmo, done;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .pend  (pend),
    .last  (last),
    .any   (pick_any),
    .grant (pick)
  );

  // Ready on the final watchdog cycle still counts as a real response.
  assign tmo  = (state == WAIT) && !l2_ready && (wd == WD_W'(TIMEOUT_CYCLES - 1));
  assign done = (state == WAIT) && (l2_ready || tmo);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    logic                  pulse, fill, clr, p_q, e_q;
    op_t                   op_q;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [LINE_W-1:0]     w_q, r_q;

    assign pulse = req_read[i] | req_write[i];
    assign clr   = (state == RESP) && (gnt == GRANT_W'(i));
    // A slot being retired this edge accepts a new pulse: set wins.
    assign fill  = pulse && (!p_q || clr);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p_q  <= 1'b0;
        op_q <= OP_RD;
        a_q  <= '0;
        w_q  <= '0;
        e_q  <= 1'b0;
        r_q  <= '0;
      end else begin
        if (fill) begin
          p_q  <= 1'b1;
          op_q <= req_write[i] ? OP_WR : OP_RD;
          a_q  <= req_addr[i];
          w_q  <= req_wdata[i];
        end else if (clr) begin
          p_q <= 1'b0;
        end
        if ((pulse && !fill) || (tmo && gnt == GRANT_W'(i))) e_q <= 1'b1;
        if (done && gnt == GRANT_W'(i)) r_q <= tmo ? '0 : l2_rdata;
      end
    end

    assign pend[i]      = p_q;
    assign op[i]        = op_q;
    assign addr[i]      = a_q;
    assign wdata[i]     = w_q;
    assign req_err[i]   = e_q;
    assign req_rdata[i] = r_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (pick_any) nxt = WAIT;
      WAIT:    if (done) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    req_hit   = '0;
    if (state == RESP) begin
      req_ready[gnt] = 1'b1;
      req_hit[gnt]   = hit_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      last     <= GRANT_W'(NUM_REQ - 1);
      l2_addr  <= '0;
      l2_wdata <= '0;
      l2_read  <= 1'b0;
      l2_write <= 1'b0;
      wd       <= '0;
      hit_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          gnt      <= pick;
          l2_addr  <= addr[pick];
          l2_wdata <= wdata[pick];
          l2_read  <= (op[pick] == OP_RD);
          l2_write <= (op[pick] == OP_WR);
          wd       <= '0;
        end
        WAIT: if (done) begin
          l2_read  <= 1'b0;
          l2_write <= 1'b0;
          hit_q    <= l2_ready & l2_hit;
        end else begin
          wd <= wd + 1'b1;
        end
        RESP: begin
          last <= gnt;
          wd   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Randomized bench for l2_arbiter against a transaction-level slot/round-robin model.
module tb_l2_arbiter;
  import l2_arb_pkg::*;

  localparam int AW = 32, DW = 32, BS = 16, NR = 2, TMO = 1024;
  localparam int LW = BS * DW;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NR-1:0]          req_read, req_write, req_ready, req_hit, req_err;
  logic [NR-1:0][AW-1:0]  req_addr;
  logic [NR-1:0][LW-1:0]  req_wdata, req_rdata;
  logic [AW-1:0]          l2_addr;
  logic [LW-1:0]          l2_wdata, l2_rdata;
  logic                   l2_read, l2_write, l2_ready, l2_hit;

  l2_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS), .NUM_REQ(NR),
               .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rdata(req_rdata),
    .req_ready(req_ready), .req_hit(req_hit), .req_err(req_err),
    .l2_addr(l2_addr), .l2_wdata(l2_wdata), .l2_read(l2_read), .l2_write(l2_write),
    .l2_rdata(l2_rdata), .l2_ready(l2_ready), .l2_hit(l2_hit)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(string tag, logic [LW-1:0] got, logic [LW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pending slots, last grant, in-flight requester.
  bit [NR-1:0]   m_pend, m_wr, m_err;
  logic [AW-1:0] m_addr  [NR];
  logic [LW-1:0] m_wdata [NR];
  int            m_last, m_busy, wait_cyc, lat_left, fix_lat;
  int            rdy_cnt [NR];
  int            grants[$];
  bit            prev_strobe, drove, expect_rdy, silent, reissue, fix_en;
  logic [LW-1:0] exp_line, fix_line;
  bit            exp_hit;

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic int pick();
    for (int k = 1; k <= NR; k++)
      if (m_pend[(m_last + k) % NR]) return (m_last + k) % NR;
    return -1;
  endfunction

  function automatic bit is_idle();
    return (m_busy < 0) && (m_pend == '0);
  endfunction

  task automatic model_reset();
    m_pend = '0; m_err = '0; m_wr = '0; m_last = NR - 1; m_busy = -1;
    prev_strobe = 0; drove = 0; expect_rdy = 0; wait_cyc = 0;
    for (int i = 0; i < NR; i++) rdy_cnt[i] = 0;
  endtask

  task automatic step();
    logic [NR-1:0]         prd, pwr, eh;
    logic [NR-1:0][AW-1:0] pa;
    logic [NR-1:0][LW-1:0] pw;
    logic                  strobe;
    int                    g;
    @(posedge clk);
    prd = req_read; pwr = req_write; pa = req_addr; pw = req_wdata;
    @(negedge clk);
    req_read = '0; req_write = '0; l2_ready = 1'b0;
    l2_rdata = rnd_line(); l2_hit = 1'($urandom());
    strobe = l2_read | l2_write;
    // a new L2 transaction must match the round-robin choice
    if (strobe && !prev_strobe) begin
      g = pick();
      chk("grant_valid", LW'(g >= 0 && m_busy < 0), LW'(1'b1));
      chk("strobe_excl", LW'(l2_read & l2_write), LW'(1'b0));
      if (g >= 0) begin
        chk("l2_addr", LW'(l2_addr), LW'(m_addr[g]));
        chk("l2_op", LW'(l2_write), LW'(m_wr[g]));
        if (m_wr[g]) chk("l2_wdata", l2_wdata, m_wdata[g]);
        grants.push_back(g);
      end
      m_busy = g; wait_cyc = 0; drove = 0;
      lat_left = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 4));
    end
    if (strobe) wait_cyc++;
    prev_strobe = strobe;
    for (int i = 0; i < NR; i++) begin
      if (prd[i] | pwr[i]) begin
        if (m_pend[i]) m_err[i] = 1'b1;
        else begin
          m_pend[i] = 1'b1; m_wr[i] = pwr[i]; m_addr[i] = pa[i]; m_wdata[i] = pw[i];
        end
      end
    end
    if (expect_rdy) begin
      chk("ready_lat", LW'(req_ready != '0), LW'(1'b1));
      expect_rdy = 0;
    end
    if (req_ready != '0) begin
      if (m_busy < 0) chk("spurious_ready", LW'(req_ready), LW'(1'b0));
      else begin
        chk("ready_sel", LW'(req_ready), LW'(NR'(1) << m_busy));
        eh = '0;
        if (drove) begin
          eh[m_busy] = exp_hit;
          chk("rdata", req_rdata[m_busy], exp_line);
        end else begin
          chk("tmo_cycles", LW'(wait_cyc), LW'(TMO));
          chk("tmo_rdata", req_rdata[m_busy], '0);
          m_err[m_busy] = 1'b1;
        end
        chk("hit", LW'(req_hit), LW'(eh));
        rdy_cnt[m_busy]++;
        m_pend[m_busy] = 1'b0; m_last = m_busy;
        if (reissue) begin req_read[m_busy] = 1'b1; req_addr[m_busy] = $urandom(); end
        m_busy = -1;
      end
    end else begin
      chk("hit_quiet", LW'(req_hit), LW'(1'b0));
    end
    chk("err", LW'(req_err), LW'(m_err));
    // L2 responder
    if (strobe && m_busy >= 0 && !silent && !drove) begin
      if (lat_left == 0) begin
        exp_line = fix_en ? fix_line : rnd_line();
        exp_hit  = fix_en ? 1'b1 : 1'($urandom());
        l2_ready = 1'b1; l2_rdata = exp_line; l2_hit = exp_hit;
        drove = 1; expect_rdy = 1;
      end else lat_left--;
    end
  endtask

  task automatic drain();
    step();
    for (int n = 0; n < 3000 && !is_idle(); n++) step();
    chk("drain_done", LW'(is_idle()), LW'(1'b1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_read = '0; req_write = '0; l2_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int base;
    req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    l2_rdata = '0; l2_ready = 1'b0; l2_hit = 1'b0;
    silent = 0; reissue = 0; fix_en = 0; fix_lat = -1;
    fix_line = {(LW/8){8'hA5}};
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_l2_read", LW'(l2_read), LW'(1'b0));
    chk("rst_l2_write", LW'(l2_write), LW'(1'b0));
    chk("rst_l2_addr", LW'(l2_addr), LW'(1'b0));
    chk("rst_ready", LW'(req_ready | req_hit | req_err), LW'(1'b0));
    chk("rst_rdata0", req_rdata[0], '0);
    rst_n = 1'b1;

    // single read, fixed 3-cycle L2 latency
    fix_en = 1; fix_lat = 2;
    req_read[0] = 1'b1; req_addr[0] = 32'h0000_0040;
    step(); chk("sr_idle", LW'(l2_read), LW'(1'b0));
    step(); chk("sr_l2_read", LW'(l2_read), LW'(1'b1));
    chk("sr_addr", LW'(l2_addr), LW'(32'h40));
    step(); step(); chk("sr_wait", LW'(req_ready), LW'(1'b0));
    step(); chk("sr_ready", LW'(req_ready), LW'(2'b01));
    chk("sr_line", req_rdata[0], fix_line);
    chk("sr_hit", LW'(req_hit), LW'(2'b01));
    step(); chk("sr_ready_off", LW'(req_ready), LW'(1'b0));
    chk("sr_hold", req_rdata[0], fix_line);
    fix_en = 0; fix_lat = -1;

    // simultaneous reads after reset
    do_reset(); grants.delete();
    req_read = 2'b11; req_addr[0] = 32'h100; req_addr[1] = 32'h200;
    drain();
    chk("sim_count", LW'(grants.size()), LW'(2));
    chk("sim_first", LW'(grants[0]), LW'(0));
    chk("sim_second", LW'(grants[1]), LW'(1));
    chk("sim_rdy0", LW'(rdy_cnt[0]), LW'(1));
    chk("sim_rdy1", LW'(rdy_cnt[1]), LW'(1));

    // fairness with continuous reissue
    do_reset(); grants.delete(); reissue = 1;
    req_read = 2'b11; req_addr[0] = $urandom(); req_addr[1] = $urandom();
    for (int n = 0; n < 200 && grants.size() < 8; n++) step();
    reissue = 0;
    drain();
    chk("fair_count", LW'(grants.size() >= 8), LW'(1'b1));
    for (int k = 0; k < 8; k++) chk("fair_order", LW'(grants[k]), LW'(k % 2));

    // overlap while pending
    do_reset(); base = grants.size();
    req_read[0] = 1'b1; req_addr[0] = 32'h300;
    step();
    req_read[0] = 1'b1; req_addr[0] = 32'h340;
    drain();
    chk("ovl_err", LW'(req_err[0]), LW'(1'b1));
    chk("ovl_txns", LW'(grants.size() - base), LW'(1));

    // watchdog timeout
    do_reset(); silent = 1;
    req_read[1] = 1'b1; req_addr[1] = 32'h400;
    drain();
    silent = 0;
    chk("tmo_err", LW'(req_err[1]), LW'(1'b1));
    chk("tmo_idle", LW'(l2_read), LW'(1'b0));

    // reset while waiting on L2, then a late ready
    do_reset(); fix_lat = 50;
    req_read[0] = 1'b1; req_addr[0] = 32'h500;
    for (int n = 0; n < 5 && !l2_read; n++) step();
    chk("rw_strobe", LW'(l2_read), LW'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("rw_l2", LW'({l2_read, l2_write, l2_addr}), LW'(1'b0));
    chk("rw_wdata", l2_wdata, '0);
    chk("rw_req", LW'({req_ready, req_hit, req_err}), LW'(1'b0));
    chk("rw_rdata0", req_rdata[0], '0);
    @(negedge clk);
    rst_n = 1'b1; model_reset(); fix_lat = -1;
    l2_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("rw_no_ready", LW'(req_ready | {NR{l2_read}}), LW'(1'b0));
    end

    // randomized mix of reads, writes and both-set pulses
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NR; i++) begin
        int r;
        r = int'($urandom_range(0, 7));
        req_read[i]  = (r == 0 || r == 2);
        req_write[i] = (r == 1 || r == 2);
        req_addr[i]  = $urandom();
        req_wdata[i] = rnd_line();
      end
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
